// File: rtl/demo_scene_seq_pkg.sv
// Timeline constants and scene encodings for the VGA demo scheduler.
// Shared by the scene sequencer and any debug overlay that needs frame boundaries.
package demo_scene_seq_pkg;

   // Frame-boundary constants
   localparam int SCROLL_IN_START  = 100;
   localparam int SCROLL_RAMP      = 69;
   localparam int TITLE_START      = SCROLL_IN_START + SCROLL_RAMP;
   localparam int PLANE_IN_START   = 209;
   localparam int PLANE_RAMP       = 240;
   localparam int PLANE_OUT_END    = 1671;
   localparam int PLANE_OUT_START  = PLANE_OUT_END - PLANE_RAMP;
   localparam int SCROLL_OUT_START = PLANE_OUT_START - SCROLL_RAMP;
   localparam int SCROLL_STEP      = 16;

   // Sized forms used by the comparators
   localparam logic [10:0] INTRO_LAST  = 11'(SCROLL_IN_START - 1);
   localparam logic [10:0] TITLE_LAST  = 11'(PLANE_IN_START - 1);
   localparam logic [10:0] CRUISE_LAST = 11'(SCROLL_OUT_START - 1);
   localparam logic [10:0] SKY_FIRST   = 11'(TITLE_START);
   localparam logic [10:0] FRAME_MAX   = 11'd2047;
   localparam logic [10:0] RESTART_MIN = 11'd8;
   localparam logic [7:0]  SCROLL_K_LAST = 8'(SCROLL_RAMP - 1);
   localparam logic [7:0]  PLANE_K_LAST  = 8'(PLANE_RAMP - 1);
   localparam logic [11:0] SCROLL_STEP_W = 12'(SCROLL_STEP);

   // Output values
   localparam logic [11:0] SCROLL_HOME = 12'd2048;
   localparam logic [11:0] SCROLL_BASE = 12'd2444;
   localparam logic [11:0] SCROLL_PARK = 12'd3548;
   localparam logic [8:0]  PLANE_LOW   = 9'd480;
   localparam logic [8:0]  PLANE_CRUISE = 9'd240;
   localparam logic [8:0]  PLANE_TOP   = 9'd0;
   localparam logic [9:0]  SKY_MAX     = 10'd1023;

   typedef enum logic [2:0] {
      SCN_INTRO      = 3'd0,
      SCN_SCROLL_IN  = 3'd1,
      SCN_TITLE      = 3'd2,
      SCN_PLANE_IN   = 3'd3,
      SCN_CRUISE     = 3'd4,
      SCN_SCROLL_OUT = 3'd5,
      SCN_PLANE_OUT  = 3'd6,
      SCN_END        = 3'd7
   } scene_e;

   // Per-state counter; saturates so long scenes cannot wrap it
   function automatic logic [7:0] k_inc(input logic [7:0] k);
      return (k == 8'hFF) ? k : k + 8'd1;
   endfunction

endpackage

// File: rtl/demo_scene_seq.sv
// Frame-rate timeline scheduler: frame counter, scene FSM and per-frame effect parameters.
// Ports: clk48, rst_n (sync, active-low), frame_tick, pause, songpos[7:0] in;
//   frame[10:0], scene[2:0], scroll_anim[11:0], plane_y_start[8:0], sky_phase[9:0],
//   sparkle_en, whiteout_en, restart out. All outputs registered, updated on unpaused ticks.
module demo_scene_seq
   import demo_scene_seq_pkg::*;
(
   input  logic        clk48,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic        pause,
   input  logic [7:0]  songpos,
   output logic [10:0] frame,
   output logic [2:0]  scene,
   output logic [11:0] scroll_anim,
   output logic [8:0]  plane_y_start,
   output logic [9:0]  sky_phase,
   output logic        sparkle_en,
   output logic        whiteout_en,
   output logic        restart
);

   scene_e      r_state, w_state_nx;
   logic [7:0]  r_k, w_k_nx;
   logic [10:0] r_frame, w_frame_nx;
   logic [11:0] r_scroll, w_scroll_nx;
   logic [8:0]  r_plane, w_plane_nx;
   logic [9:0]  r_sky, w_sky_nx;
   logic        r_spark, w_spark_nx;
   logic        r_white, w_white_nx;
   logic        r_restart, w_restart_nx;

   logic        w_event;
   logic        w_restart;

   assign w_event   = frame_tick & ~pause;
   assign w_restart = (r_frame > RESTART_MIN) && (songpos == 8'd0);

   always_ff @(posedge clk48) begin
      if (!rst_n) begin
         r_state   <= SCN_INTRO;
         r_k       <= 8'd0;
         r_frame   <= 11'd0;
         r_scroll  <= SCROLL_HOME;
         r_plane   <= PLANE_LOW;
         r_sky     <= 10'd0;
         r_spark   <= 1'b0;
         r_white   <= 1'b0;
         r_restart <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_k       <= w_k_nx;
         r_frame   <= w_frame_nx;
         r_scroll  <= w_scroll_nx;
         r_plane   <= w_plane_nx;
         r_sky     <= w_sky_nx;
         r_spark   <= w_spark_nx;
         r_white   <= w_white_nx;
         r_restart <= w_restart_nx;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_k_nx       = r_k;
      w_frame_nx   = r_frame;
      w_scroll_nx  = r_scroll;
      w_plane_nx   = r_plane;
      w_sky_nx     = r_sky;
      w_spark_nx   = r_spark;
      w_white_nx   = r_white;
      w_restart_nx = 1'b0;

      if (w_event) begin
         if (w_restart) begin
            w_state_nx   = SCN_INTRO;
            w_k_nx       = 8'd0;
            w_frame_nx   = 11'd0;
            w_scroll_nx  = SCROLL_HOME;
            w_plane_nx   = PLANE_LOW;
            w_sky_nx     = 10'd0;
            w_spark_nx   = 1'b0;
            w_white_nx   = 1'b0;
            w_restart_nx = 1'b1;
         end else begin
            if (r_state != SCN_END || r_frame != FRAME_MAX)
               w_frame_nx = r_frame + 11'd1;

            // Old frame >= 169 means new frame >= 170, i.e. phase >= 1
            if (r_frame >= SKY_FIRST && r_sky != SKY_MAX)
               w_sky_nx = r_sky + 10'd1;

            w_spark_nx = (songpos[7:6] > 2'd1);
            w_white_nx = (songpos[7:6] == 2'd3);
            w_k_nx     = k_inc(r_k);

            unique case (r_state)
               SCN_INTRO: begin
                  if (r_frame == INTRO_LAST) begin
                     w_state_nx  = SCN_SCROLL_IN;
                     w_k_nx      = 8'd0;
                     w_scroll_nx = SCROLL_BASE;
                  end
               end
               SCN_SCROLL_IN: begin
                  if (r_k == SCROLL_K_LAST) begin
                     w_state_nx  = SCN_TITLE;
                     w_k_nx      = 8'd0;
                     w_scroll_nx = SCROLL_PARK;
                  end else begin
                     w_scroll_nx = r_scroll + SCROLL_STEP_W;
                  end
               end
               SCN_TITLE: begin
                  if (r_frame == TITLE_LAST) begin
                     w_state_nx = SCN_PLANE_IN;
                     w_k_nx     = 8'd0;
                     w_plane_nx = PLANE_LOW;
                  end
               end
               SCN_PLANE_IN: begin
                  if (r_k == PLANE_K_LAST) begin
                     w_state_nx  = SCN_CRUISE;
                     w_k_nx      = 8'd0;
                     w_plane_nx  = PLANE_CRUISE;
                     w_scroll_nx = SCROLL_PARK;
                  end else begin
                     w_plane_nx = r_plane - 9'd1;
                  end
               end
               SCN_CRUISE: begin
                  if (r_frame == CRUISE_LAST) begin
                     w_state_nx  = SCN_SCROLL_OUT;
                     w_k_nx      = 8'd0;
                     w_scroll_nx = SCROLL_PARK;
                     w_plane_nx  = PLANE_CRUISE;
                  end
               end
               SCN_SCROLL_OUT: begin
                  // The fly-out runs past 4095 and wraps; the scroller is periodic
                  if (r_k == SCROLL_K_LAST) begin
                     w_state_nx  = SCN_PLANE_OUT;
                     w_k_nx      = 8'd0;
                     w_scroll_nx = SCROLL_HOME;
                     w_plane_nx  = PLANE_CRUISE;
                  end else begin
                     w_scroll_nx = r_scroll + SCROLL_STEP_W;
                  end
               end
               SCN_PLANE_OUT: begin
                  if (r_k == PLANE_K_LAST) begin
                     w_state_nx  = SCN_END;
                     w_k_nx      = 8'd0;
                     w_scroll_nx = SCROLL_HOME;
                     w_plane_nx  = PLANE_TOP;
                  end else begin
                     w_plane_nx = r_plane - 9'd1;
                  end
               end
               SCN_END: begin
                  w_scroll_nx = SCROLL_HOME;
                  w_plane_nx  = PLANE_TOP;
               end
            endcase
         end
      end
   end

   assign frame         = r_frame;
   assign scene         = r_state;
   assign scroll_anim   = r_scroll;
   assign plane_y_start = r_plane;
   assign sky_phase     = r_sky;
   assign sparkle_en    = r_spark;
   assign whiteout_en   = r_white;
   assign restart       = r_restart;

endmodule

// File: tb/tb_demo_scene_seq.sv
// Directed bench for demo_scene_seq: ticks every 8 clocks, checks one clock after each tick.
module tb_demo_scene_seq;

   logic        clk48 = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic        pause = 1'b0;
   logic [7:0]  songpos = 8'h10;
   logic [10:0] frame;
   logic [2:0]  scene;
   logic [11:0] scroll_anim;
   logic [8:0]  plane_y_start;
   logic [9:0]  sky_phase;
   logic        sparkle_en;
   logic        whiteout_en;
   logic        restart;

   int errs = 0;
   int checks = 0;

   demo_scene_seq dut (
      .clk48(clk48), .rst_n(rst_n), .frame_tick(frame_tick),
      .pause(pause), .songpos(songpos), .frame(frame), .scene(scene),
      .scroll_anim(scroll_anim), .plane_y_start(plane_y_start),
      .sky_phase(sky_phase), .sparkle_en(sparkle_en),
      .whiteout_en(whiteout_en), .restart(restart)
   );

   always #10 clk48 = ~clk48;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      repeat (6) @(negedge clk48);
      @(negedge clk48) frame_tick = 1'b1;
      @(negedge clk48) frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_rst(input string p);
      chk({p, "_frame"}, 32'(frame), 0);
      chk({p, "_scene"}, 32'(scene), 0);
      chk({p, "_scroll"}, 32'(scroll_anim), 2048);
      chk({p, "_plane"}, 32'(plane_y_start), 480);
      chk({p, "_sky"}, 32'(sky_phase), 0);
      chk({p, "_spark"}, 32'(sparkle_en), 0);
      chk({p, "_white"}, 32'(whiteout_en), 0);
   endtask

   initial begin
      // 1: reset and scroller entry
      repeat (3) @(posedge clk48);
      @(negedge clk48) rst_n = 1'b1;
      chk_rst("rst");
      chk("rst_restart", 32'(restart), 0);
      ticks(100);
      chk("f100", 32'(frame), 100);
      chk("f100_scene", 32'(scene), 1);
      chk("f100_scroll", 32'(scroll_anim), 2444);

      // 2: end of fly-in, title, sky start
      ticks(68);
      chk("f168_scroll", 32'(scroll_anim), 3532);
      tick();
      chk("f169_scene", 32'(scene), 2);
      chk("f169_scroll", 32'(scroll_anim), 3548);
      chk("f169_sky", 32'(sky_phase), 0);
      tick();
      chk("f170_sky", 32'(sky_phase), 1);

      // 3: plane rise and cruise
      ticks(39);
      chk("f209_scene", 32'(scene), 3);
      chk("f209_plane", 32'(plane_y_start), 480);
      ticks(239);
      chk("f448_plane", 32'(plane_y_start), 241);
      tick();
      chk("f449_scene", 32'(scene), 4);
      chk("f449_plane", 32'(plane_y_start), 240);
      chk("f449_scroll", 32'(scroll_anim), 3548);
      chk("f449_sky", 32'(sky_phase), 280);

      // 4: restart from frame 500, then songpos=0 early in the pass
      ticks(51);
      chk("f500", 32'(frame), 500);
      songpos = 8'h00;
      tick();
      chk("rs_pulse", 32'(restart), 1);
      chk_rst("rs");
      @(negedge clk48);
      chk("rs_pulse_end", 32'(restart), 0);
      ticks(5);
      chk("early_f5", 32'(frame), 5);
      tick();
      chk("early_f6", 32'(frame), 6);
      chk("early_norst", 32'(restart), 0);
      songpos = 8'h10;

      // 5: pause at frame 300, then reset mid-ramp
      ticks(294);
      chk("p_f300", 32'(frame), 300);
      chk("p_plane", 32'(plane_y_start), 389);
      pause = 1'b1;
      songpos = 8'hC0;
      ticks(10);
      chk("p_frame", 32'(frame), 300);
      chk("p_scene", 32'(scene), 3);
      chk("p_plane_hold", 32'(plane_y_start), 389);
      chk("p_scroll", 32'(scroll_anim), 3548);
      chk("p_sky", 32'(sky_phase), 131);
      chk("p_spark", 32'(sparkle_en), 0);
      pause = 1'b0;
      songpos = 8'h10;
      ticks(1100);
      chk("f1400", 32'(frame), 1400);
      chk("f1400_scene", 32'(scene), 5);
      chk("f1400_scroll", 32'(scroll_anim), 60);
      @(negedge clk48) rst_n = 1'b0;
      @(negedge clk48);
      chk_rst("mid_rst");
      rst_n = 1'b1;

      // 6: fall, end, saturation and song flags
      ticks(1670);
      chk("f1670_scene", 32'(scene), 6);
      chk("f1670_plane", 32'(plane_y_start), 1);
      tick();
      chk("f1671", 32'(frame), 1671);
      chk("end_scene", 32'(scene), 7);
      chk("end_plane", 32'(plane_y_start), 0);
      chk("end_scroll", 32'(scroll_anim), 2048);
      chk("end_sky", 32'(sky_phase), 1023);
      ticks(376);
      chk("f2047", 32'(frame), 2047);
      ticks(3);
      chk("f_sat", 32'(frame), 2047);
      songpos = 8'h80;
      tick();
      chk("s80_spark", 32'(sparkle_en), 1);
      chk("s80_white", 32'(whiteout_en), 0);
      songpos = 8'hC4;
      repeat (2) @(negedge clk48);
      chk("sC4_mid_white", 32'(whiteout_en), 0);
      tick();
      chk("sC4_spark", 32'(sparkle_en), 1);
      chk("sC4_white", 32'(whiteout_en), 1);
      chk("sC4_norst", 32'(restart), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
